// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: control sequencer for a time-multiplexed symmetric 63-tap FIR.
// Writes one sample per pass into a 63-entry circular delay line, then walks 32 MAC cycles.
module fir_tap_sequencer #(
    parameter int PIPE = 2
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       i_sample_valid,
    output logic       o_sample_ready,
    output logic       o_wr_en,
    output logic [5:0] o_wr_addr,
    output logic [4:0] o_coef_addr,
    output logic [5:0] o_rd_addr_a,
    output logic [5:0] o_rd_addr_b,
    output logic       o_pair_en,
    output logic       o_mac_en,
    output logic       o_acc_clr,
    output logic       o_out_valid,
    input  logic       i_out_ready
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t     r_state, w_state_nxt;
    logic [5:0] r_wr_ptr, r_rd_a, r_rd_b, w_wr_ptr_nxt, w_rd_a_nxt, w_rd_b_nxt, w_wr_inc;
    logic [4:0] r_k, w_k_nxt;
    logic [2:0] r_drain, w_drain_nxt;
    logic       w_accept;

    assign w_accept = (r_state == IDLE) && i_sample_valid;
    assign w_wr_inc = (r_wr_ptr == 6'd62) ? 6'd0 : r_wr_ptr + 6'd1;

    // Read addresses step incrementally mod 63: side a walks back from newest, side b forward from newest+1.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_a_nxt   = r_rd_a;
        w_rd_b_nxt   = r_rd_b;
        w_k_nxt      = r_k;
        w_drain_nxt  = r_drain;
        case (r_state)
            IDLE: if (w_accept) begin
                w_state_nxt  = RUN;
                w_wr_ptr_nxt = w_wr_inc;
                w_rd_a_nxt   = r_wr_ptr;
                w_rd_b_nxt   = w_wr_inc;
                w_k_nxt      = 5'd0;
            end
            RUN: if (r_k == 5'd31) begin
                w_state_nxt = DRAIN;
                w_drain_nxt = 3'(PIPE);
            end else begin
                w_k_nxt    = r_k + 5'd1;
                w_rd_a_nxt = (r_rd_a == 6'd0) ? 6'd62 : r_rd_a - 6'd1;
                w_rd_b_nxt = (r_rd_b == 6'd62) ? 6'd0 : r_rd_b + 6'd1;
            end
            DRAIN: if (r_drain == 3'd1) w_state_nxt = DONE;
                   else w_drain_nxt = r_drain - 3'd1;
            DONE: if (i_out_ready) w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state  <= IDLE;
            r_wr_ptr <= 6'd0;
            r_rd_a   <= 6'd0;
            r_rd_b   <= 6'd0;
            r_k      <= 5'd0;
            r_drain  <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_a   <= w_rd_a_nxt;
            r_rd_b   <= w_rd_b_nxt;
            r_k      <= w_k_nxt;
            r_drain  <= w_drain_nxt;
        end
    end

    assign o_sample_ready = (r_state == IDLE);
    assign o_wr_en        = w_accept;
    assign o_wr_addr      = r_wr_ptr;
    assign o_coef_addr    = r_k;
    assign o_rd_addr_a    = r_rd_a;
    assign o_rd_addr_b    = r_rd_b;
    assign o_mac_en       = (r_state == RUN);
    assign o_pair_en      = (r_state == RUN) && (r_k != 5'd31);
    assign o_acc_clr      = (r_state == RUN) && (r_k == 5'd0);
    assign o_out_valid    = (r_state == DONE);
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: randomized and directed checks of fir_tap_sequencer
// against a timeline model (cycles elapsed since the last accept).
module tb_fir_tap_sequencer;
    localparam int PIPE   = 2;
    localparam int DONE_T = 33 + PIPE;
    localparam logic [28:0] RST = 29'h1000_0000;

    logic CLK = 1'b0, CLR = 1'b0, sv = 1'b0, ordy = 1'b0;
    logic sample_ready, wr_en, pair_en, mac_en, acc_clr, out_valid;
    logic [5:0] wr_addr, rd_addr_a, rd_addr_b;
    logic [4:0] coef_addr;
    logic [28:0] obs, exp_v;
    int checks = 0, failures = 0;

    always #5 CLK = ~CLK;

    fir_tap_sequencer #(.PIPE(PIPE)) dut (
        .CLK(CLK), .CLR(CLR), .i_sample_valid(sv), .o_sample_ready(sample_ready),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_coef_addr(coef_addr),
        .o_rd_addr_a(rd_addr_a), .o_rd_addr_b(rd_addr_b), .o_pair_en(pair_en),
        .o_mac_en(mac_en), .o_acc_clr(acc_clr), .o_out_valid(out_valid), .i_out_ready(ordy)
    );

    assign obs = {sample_ready, wr_en, wr_addr, coef_addr, rd_addr_a, rd_addr_b,
                  pair_en, mac_en, acc_clr, out_valid};

    // m_t: 0 idle, 1..32 MAC cycle k=m_t-1, then drain, DONE_T waits for out_ready
    int   m_t, m_wr, m_new, e_k, e_a, e_b;
    logic m_av, e_run;

    always @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            m_t <= 0; m_wr <= 0; m_new <= 0; m_av <= 1'b0;
        end else if (m_t == 0) begin
            if (sv) begin
                m_new <= m_wr; m_wr <= (m_wr + 1) % 63; m_t <= 1; m_av <= 1'b1;
            end
        end else if (m_t < DONE_T) m_t <= m_t + 1;
        else if (ordy) m_t <= 0;
    end

    always_comb begin
        e_run = (m_t >= 1) && (m_t <= 32);
        e_k   = e_run ? m_t - 1 : (m_av ? 31 : 0);
        e_a   = m_av ? (m_new + 63 - e_k) % 63 : 0;
        e_b   = m_av ? (m_new + 1 + e_k) % 63 : 0;
        exp_v = {m_t == 0, (m_t == 0) && sv, 6'(m_wr), 5'(e_k), 6'(e_a), 6'(e_b),
                 e_run && (e_k != 31), e_run, e_run && (e_k == 0), m_t == DONE_T};
    end

    task automatic cyc(input logic v, input logic r);
        @(negedge CLK);
        sv = v; ordy = r;
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        sv = 1'b0; ordy = 1'b0; CLR = 1'b1;
        #2 CLR = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        sv = 1'b0; ordy = 1'b0; CLR = 1'b1;
        repeat (2) @(negedge CLK);
        CLR = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0);
            checks++;
            if (obs !== RST) begin failures++; $display("FAIL reset_values obs=%h exp=%h", obs, RST); end
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL reset_model obs=%h exp=%h", obs, exp_v); end
        end
    endtask

    task automatic test_first_sample();
        int lat = -1;
        cyc(1'b1, 1'b1);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd0) begin
            failures++; $display("FAIL first_write wr_en=%b wr_addr=%0d exp 1/0", wr_en, wr_addr);
        end
        for (int n = 1; n <= 40; n++) begin
            cyc(1'b0, 1'b1);
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL first_model n=%0d obs=%h exp=%h", n, obs, exp_v); end
            if (n == 1) begin
                checks++;
                if (rd_addr_a !== 6'd0 || rd_addr_b !== 6'd1 || acc_clr !== 1'b1) begin
                    failures++; $display("FAIL first_k0 a=%0d b=%0d clr=%b exp 0/1/1", rd_addr_a, rd_addr_b, acc_clr);
                end
            end
            if (n == 32) begin
                checks++;
                if (rd_addr_a !== 6'd32 || rd_addr_b !== 6'd32 || pair_en !== 1'b0) begin
                    failures++; $display("FAIL first_k31 a=%0d b=%0d pair=%b exp 32/32/0", rd_addr_a, rd_addr_b, pair_en);
                end
            end
            if (out_valid === 1'b1 && lat < 0) lat = n;
        end
        checks++;
        if (lat != 35) begin failures++; $display("FAIL first_latency got=%0d exp=35", lat); end
    endtask

    task automatic test_back_to_back();
        int acc = 0, last = 0, mac_cnt = 0, clr_cnt = 0;
        do_reset();
        for (int c = 0; c <= 63 * 36; c++) begin
            cyc(1'b1, 1'b1);
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL b2b_model c=%0d obs=%h exp=%h", c, obs, exp_v); end
            if (c == 62 * 36 + 1) begin
                checks++;
                if (rd_addr_a !== 6'd62 || rd_addr_b !== 6'd0) begin
                    failures++; $display("FAIL wrap_k0 a=%0d b=%0d exp 62/0", rd_addr_a, rd_addr_b);
                end
            end
            if (c == 62 * 36 + 32) begin
                checks++;
                if (rd_addr_a !== 6'd31 || rd_addr_b !== 6'd31) begin
                    failures++; $display("FAIL wrap_k31 a=%0d b=%0d exp 31/31", rd_addr_a, rd_addr_b);
                end
            end
            if (wr_en === 1'b1) begin
                checks++;
                if (wr_addr !== 6'(acc % 63)) begin
                    failures++; $display("FAIL b2b_wr_addr got=%0d exp=%0d", wr_addr, acc % 63);
                end
                if (acc > 0) begin
                    checks++;
                    if (c - last != 36 || mac_cnt != 32 || clr_cnt != 1) begin
                        failures++;
                        $display("FAIL b2b_pass gap=%0d mac=%0d clr=%0d exp 36/32/1", c - last, mac_cnt, clr_cnt);
                    end
                end
                acc++; last = c; mac_cnt = 0; clr_cnt = 0;
            end
            mac_cnt += int'(mac_en);
            clr_cnt += int'(acc_clr);
        end
        checks++;
        if (acc != 64) begin failures++; $display("FAIL b2b_accepts got=%0d exp=64", acc); end
    endtask

    task automatic test_backpressure();
        int found = 0;
        logic [28:0] snap;
        do_reset();
        cyc(1'b1, 1'b0);
        for (int n = 0; n < 50 && found == 0; n++) begin
            cyc(1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL bp_model obs=%h exp=%h", obs, exp_v); end
            if (out_valid === 1'b1) found = 1;
        end
        checks++;
        if (found == 0) begin failures++; $display("FAIL bp_timeout out_valid=%b exp=1", out_valid); end
        snap = obs;
        for (int i = 0; i < 10; i++) begin
            cyc((i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
            checks++;
            if (out_valid !== 1'b1 || sample_ready !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 6'd1) begin
                failures++;
                $display("FAIL bp_hold ov=%b rdy=%b we=%b wa=%0d exp 1/0/0/1", out_valid, sample_ready, wr_en, wr_addr);
            end
            checks++;
            if (obs !== snap || obs !== exp_v) begin
                failures++; $display("FAIL bp_frozen obs=%h exp=%h", obs, snap);
            end
        end
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        checks++;
        if (sample_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_release rdy=%b ov=%b exp 1/0", sample_ready, out_valid);
        end
        cyc(1'b1, 1'b1);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd1) begin
            failures++; $display("FAIL bp_next_write we=%b wa=%0d exp 1/1", wr_en, wr_addr);
        end
    endtask

    task automatic test_clr_mid();
        do_reset();
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        for (int n = 1; n < 16; n++) cyc(1'b0, 1'b1);
        checks++;
        if (coef_addr !== 5'd15 || mac_en !== 1'b1 || wr_addr !== 6'd1) begin
            failures++; $display("FAIL clr_pre k=%0d mac=%b wa=%0d exp 15/1/1", coef_addr, mac_en, wr_addr);
        end
        CLR = 1'b1;
        #1;
        checks++;
        if (obs !== RST) begin failures++; $display("FAIL clr_async obs=%h exp=%h", obs, RST); end
        @(negedge CLK);
        CLR = 1'b0;
        for (int n = 0; n < 40; n++) begin
            cyc(1'b0, 1'b1);
            checks++;
            if (out_valid !== 1'b0 || obs !== exp_v) begin
                failures++; $display("FAIL clr_after obs=%h exp=%h", obs, exp_v);
            end
        end
        cyc(1'b1, 1'b1);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd0) begin
            failures++; $display("FAIL clr_next_write we=%b wa=%0d exp 1/0", wr_en, wr_addr);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL random_model n=%0d obs=%h exp=%h", n, obs, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_back_to_back();
        test_backpressure();
        test_clr_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Control sequencer for the time-multiplexed symmetric 63-tap FIR. It accepts one input sample per filter pass and writes that sample into a 63-entry circular delay-line RAM. It then steps a 5-bit coefficient index through 32 MAC cycles (31 symmetric pairs plus the centre tap), driving the paired read addresses and the accumulator controls, and holds a valid/ready output handshake until the result is taken.

## Interface
- PIPE, 2, MAC datapath latency in cycles from last mac_en to result available (1..4)
- CLK  in  1  clock, rising edge
- CLR  in  1  asynchronous reset, active-high
- sample_valid  in  1  new input sample offered
- sample_ready  out  1  sequencer can accept a sample (high only in IDLE)
- wr_en  out  1  delay-line write strobe, = sample_valid & sample_ready
- wr_addr  out  6  delay-line write address (= wr_ptr, 0..62)
- coef_addr  out  5  coefficient index k, 0..31
- rd_addr_a  out  6  newer-side sample address, (newest − k) mod 63
- rd_addr_b  out  6  older-side sample address, (newest + 1 + k) mod 63
- pair_en  out  1  1 = add both samples (k<31); 0 = centre tap, use rd_addr_a only
- mac_en  out  1  MAC performs a multiply-accumulate this cycle
- acc_clr  out  1  with mac_en, load product instead of accumulating (k=0)
- out_valid  out  1  filter result valid
- out_ready  in  1  downstream takes result

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: sample_ready=1. When sample_valid=1, wr_en=1 in the same cycle with wr_addr=wr_ptr. Latch newest=wr_ptr, advance wr_ptr ((62→0) wrap), set k=0, go to RUN.
- RUN: mac_en=1 every cycle. acc_clr=1 only at k=0. pair_en=1 for k=0..30 and 0 at k=31. k increments by 1 each cycle. After k=31, go to DRAIN with drain count PIPE.
- DRAIN: mac_en=0. Count PIPE cycles, then go to DONE.
- DONE: out_valid=1. Hold it until out_ready=1, then go to IDLE. out_valid is not asserted in any other state.
- Address arithmetic is mod 63, using 6-bit values, never 64. At k=31, rd_addr_a = rd_addr_b = newest − 31 mod 63.
- sample_valid outside IDLE is ignored: no write, and wr_ptr does not change.
- coef_addr, rd_addr_a and rd_addr_b hold their last values outside RUN. They are don't-care for the datapath when mac_en=0.
- CLR at any time: state=IDLE, wr_ptr=0, newest=0, k=0, drain count=0. In-flight pass is abandoned and no out_valid is produced. Delay-line contents are not cleared by this block.

## Timing
- Reset values: sample_ready=1, wr_en=0 (given sample_valid=0), wr_addr=0, coef_addr=0, rd_addr_a=0, rd_addr_b=0, pair_en=0, mac_en=0, acc_clr=0, out_valid=0.
- Accept at cycle T leads to RUN cycles T+1..T+32, DRAIN cycles T+33..T+32+PIPE, and out_valid first high at T+33+PIPE.
- If out_ready=1 in the first DONE cycle, the block is back in IDLE at T+34+PIPE. The minimum pass period is 34+PIPE cycles (36 at PIPE=2).
- Read addresses and coef_addr are registered and change on the clock edge that starts each RUN cycle.
- mac_en, acc_clr and pair_en are aligned to the same cycle as the addresses they qualify.
- Backpressure: out_valid stays high and all outputs stay frozen while out_ready=0, for any number of cycles.

## Test plan
- Reset, then idle for 5 cycles → every output at its reset value, sample_ready=1, no wr_en.
- First sample after reset → wr_addr=0. At k=0: rd_addr_a=0, rd_addr_b=1, acc_clr=1. At k=31: rd_addr_a=rd_addr_b=32, pair_en=0. out_valid appears exactly 35 cycles after accept (PIPE=2).
- Drive 63 passes back-to-back with out_ready=1 → wr_addr goes 0..62. On the 64th accept wr_addr=0. On the pass with newest=62: k=0 gives rd_addr_a=62, rd_addr_b=0, and k=31 gives both at 31.
- Hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, sample_ready stays 0. A sample_valid pulse during the hold produces no wr_en and wr_ptr stays unchanged. Release → IDLE on the next cycle.
- Assert CLR at k=15 of a pass → state is IDLE immediately. mac_en=0, no out_valid, wr_ptr=0. The next accepted sample writes address 0.
- Hold sample_valid high continuously with out_ready=1 → exactly one accept per 36 cycles. Each pass shows mac_en high for exactly 32 cycles, with acc_clr high once per pass.
